// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP state machine: sequences IR/DR capture, shift and update strobes
// from TMS and produces a negedge-timed TDO output enable.
module tap_controller (
  input  logic       TCLK,
  input  logic       TRESETN,
  input  logic       TMS,
  output logic       CaptureIR,
  output logic       ShiftIR,
  output logic       UpdateIR,
  output logic       CaptureDR,
  output logic       ShiftDR,
  output logic       UpdateDR,
  output logic       TestLogicReset,
  output logic       RunTestIdle,
  output logic       SelectIR,
  output logic [3:0] State,
  output logic       TDO_EN
);

  typedef enum logic [3:0] {
    EX2DR   = 4'h0,
    EX1DR   = 4'h1,
    SHDR    = 4'h2,
    PAUSEDR = 4'h3,
    SELIR   = 4'h4,
    UPDDR   = 4'h5,
    CAPDR   = 4'h6,
    SELDR   = 4'h7,
    EX2IR   = 4'h8,
    EX1IR   = 4'h9,
    SHIR    = 4'hA,
    PAUSEIR = 4'hB,
    RTI     = 4'hC,
    UPDIR   = 4'hD,
    CAPIR   = 4'hE,
    TLR     = 4'hF
  } tapState_t;

  tapState_t curState, nxtState;

  always_ff @(posedge TCLK or negedge TRESETN) begin
    if (!TRESETN) curState <= TLR;
    else          curState <= nxtState;
  end

  always_comb begin
    nxtState = curState;
    case (curState)
      TLR:     nxtState = TMS ? TLR     : RTI;
      RTI:     nxtState = TMS ? SELDR   : RTI;
      SELDR:   nxtState = TMS ? SELIR   : CAPDR;
      CAPDR:   nxtState = TMS ? EX1DR   : SHDR;
      SHDR:    nxtState = TMS ? EX1DR   : SHDR;
      EX1DR:   nxtState = TMS ? UPDDR   : PAUSEDR;
      PAUSEDR: nxtState = TMS ? EX2DR   : PAUSEDR;
      EX2DR:   nxtState = TMS ? UPDDR   : SHDR;
      UPDDR:   nxtState = TMS ? SELDR   : RTI;
      SELIR:   nxtState = TMS ? TLR     : CAPIR;
      CAPIR:   nxtState = TMS ? EX1IR   : SHIR;
      SHIR:    nxtState = TMS ? EX1IR   : SHIR;
      EX1IR:   nxtState = TMS ? UPDIR   : PAUSEIR;
      PAUSEIR: nxtState = TMS ? EX2IR   : PAUSEIR;
      EX2IR:   nxtState = TMS ? UPDIR   : SHIR;
      UPDIR:   nxtState = TMS ? SELDR   : RTI;
      default: nxtState = TLR;
    endcase
  end

  // Pure state decode keeps every strobe free of any combinational TMS path.
  assign CaptureIR      = (curState == CAPIR);
  assign ShiftIR        = (curState == SHIR);
  assign UpdateIR       = (curState == UPDIR);
  assign CaptureDR      = (curState == CAPDR);
  assign ShiftDR        = (curState == SHDR);
  assign UpdateDR       = (curState == UPDDR);
  assign TestLogicReset = (curState == TLR);
  assign RunTestIdle    = (curState == RTI);
  assign SelectIR       = (curState == SELIR) || (curState == CAPIR) || (curState == SHIR) ||
                          (curState == EX1IR) || (curState == PAUSEIR) ||
                          (curState == EX2IR) || (curState == UPDIR);
  assign State          = curState;

  // Enable follows Shift residency half a cycle late so TDO changes on the falling edge.
  always_ff @(negedge TCLK or negedge TRESETN) begin
    if (!TRESETN) TDO_EN <= 1'b0;
    else          TDO_EN <= (curState == SHIR) || (curState == SHDR);
  end

endmodule

// File: doc/tap_controller.md
Name: tap_controller

Overview:
IEEE 1149.1 TAP state machine that sequences the JTAG instruction and data registers. It decodes TMS on TCLK and drives the CaptureIR/ShiftIR/UpdateIR strobes consumed directly by the 8-bit instruction register, plus the equivalent DR strobes for data registers. It also generates a test-logic-reset indication and a negedge-timed TDO output enable.

Parameters:
none (state encoding and transition table fixed by IEEE 1149.1, listed below)

Ports:
TCLK  input  1  test clock; state advances on posedge
TRESETN  input  1  asynchronous, active-low reset; forces Test-Logic-Reset
TMS  input  1  test mode select, sampled on posedge TCLK
CaptureIR  output  1  high while state = Capture-IR
ShiftIR  output  1  high while state = Shift-IR
UpdateIR  output  1  high while state = Update-IR
CaptureDR  output  1  high while state = Capture-DR
ShiftDR  output  1  high while state = Shift-DR
UpdateDR  output  1  high while state = Update-DR
TestLogicReset  output  1  high while state = Test-Logic-Reset
RunTestIdle  output  1  high while state = Run-Test/Idle
SelectIR  output  1  high in any IR-column state (Select-IR through Update-IR); drives the TDO source mux
State  output  4  current state code, for debug and observability
TDO_EN  output  1  TDO driver enable; registered on negedge TCLK

Behaviour:
- State register: 4 bits, updated on posedge TCLK; async clear to TLR (4'hF) when TRESETN is low.
- Encoding: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
- Next state, written as TMS=0 / TMS=1:
  - TLR: RTI / TLR
  - RTI: RTI / SelDR
  - SelDR: CapDR / SelIR
  - SelIR: CapIR / TLR
  - CapXR: ShXR / Ex1XR
  - ShXR: ShXR / Ex1XR
  - Ex1XR: PauseXR / UpdXR
  - PauseXR: PauseXR / Ex2XR
  - Ex2XR: ShXR / UpdXR
  - UpdXR: RTI / SelDR
  - (X = I or D; IR and DR columns are symmetric)
- Strobe timing:
  - All strobes except TDO_EN are a pure Moore decode of the state register, with no TMS path, so they are glitch-free relative to posedge.
  - A strobe is high for exactly the TCLK cycles spent in its state.
  - Capture and Shift are sampled by the registers on the following posedge.
  - UpdateIR/UpdateDR are sampled by the parallel latches on the negedge inside the Update state.
- TDO_EN:
  - Negedge flop, async reset to 0.
  - Loads 1 on a negedge where the state is ShIR or ShDR; loads 0 otherwise.
  - Result: TDO_EN rises half a cycle after Shift entry and falls half a cycle after Shift exit.
- SelectIR: decode of states {SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR}.
- Reset values:
  - State = F, TestLogicReset = 1.
  - All Capture/Shift/Update strobes = 0; RunTestIdle = 0; SelectIR = 0; TDO_EN = 0.
- Invariants:
  - From any state, 5 consecutive posedges with TMS=1 end in TLR.
  - TLR holds indefinitely while TMS=1.
- Reset mid-operation: asserting TRESETN in any state, including ShIR or UpdIR, forces TLR and deasserts all strobes immediately (asynchronously). TDO_EN clears at the same time.
- Release: on TRESETN deassertion the first posedge evaluates from TLR. No strobe is ever asserted in the reset cycle.
- Mutual exclusion: at most one of the six Capture/Shift/Update strobes is high at any time.
- Shift/capture interaction: the IR depends on ShiftIR and CaptureIR never being high together. This holds by construction of the decode.

Test Plan:
- Reset then TMS = 0,1,1,0,0:
  - States go C, 7, 4, E, A.
  - CaptureIR is high only in the 4th cycle; ShiftIR goes high in the 5th; TDO_EN rises at the following negedge.
- In ShIR, hold TMS=0 for 7 clocks then TMS=1, then 1 (Ex1IR, then UpdIR):
  - ShiftIR stays high 8 cycles; UpdateIR is high exactly 1 cycle.
  - The IR PO equals the last 8 SI bits after the Update negedge.
  - Then TMS=0 returns to RunTestIdle=1.
- From each of the 16 states, apply 5 posedges with TMS=1 -> State = F and TestLogicReset = 1 in every case.
- DR path: from RTI, TMS = 1,0,0,1,0,0,0,1,0,1,1:
  - Visits SelDR, CapDR, ShDR, Ex1DR, then PauseDR for 3 cycles, then Ex2DR, ShDR, Ex1DR, UpdDR.
  - ShiftDR/UpdateDR pulse at the matching cycles; no IR strobe ever rises.
- Pull TRESETN low mid-cycle while in ShIR with TDO_EN=1:
  - State goes to F and ShiftIR, TDO_EN go to 0 without a clock edge.
  - After release, TMS=0 moves to RTI on the first posedge.
- Random TMS for 10k cycles against a reference transition table:
  - State matches every cycle.
  - Strobes are one-hot-or-zero at all times.
  - SelectIR equals the IR-column decode at all times.
